// File: rtl/ay_video_pkg.sv
// Shared definitions for the AY-3-8500 video front end.
//   - timing-constant functions: each takes the clkvideo frequency in kHz
//     and returns a cycle count
//   - default object colours and the 9-bit {r,g,b} colour layout
//   - 12-bit saturating counter width and increment helper
//   - vertical-sync state encoding
package ay_video_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  localparam logic [8:0] COL_BALL_DEF = 9'o777;  // white
  localparam logic [8:0] COL_RP_DEF   = 9'o070;  // green
  localparam logic [8:0] COL_LP_DEF   = 9'o700;  // red
  localparam logic [8:0] COL_SF_DEF   = 9'o777;  // white

  localparam int              CNT_W   = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Durations in ns times kHz, scaled back to cycles.
  function automatic int hsync_w(input int clk_khz);
    return clk_khz * 4700 / 1000000;
  endfunction

  function automatic int line_min(input int clk_khz);
    return clk_khz * 48000 / 1000000;
  endfunction

  function automatic int line_max(input int clk_khz);
    return clk_khz * 68000 / 1000000;
  endfunction

  function automatic int vs_thresh(input int clk_khz);
    return clk_khz * 12000 / 1000000;
  endfunction

  function automatic int vs_end(input int clk_khz);
    return clk_khz * 20000 / 1000000;
  endfunction

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  typedef enum logic {
    VS_IDLE   = 1'b0,  // vsync_ext_n high
    VS_ACTIVE = 1'b1   // vsync_ext_n low
  } vs_state_t;

endpackage

// File: rtl/ay_video_frontend_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Parameters: WIDTH (bus width), RST_VAL (value of both stages in reset).
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronised output (two clk edges later)
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ay_video_frontend.sv
// AY-3-8500 video front end: splits the chip's composite sync into clean
// hsync/vsync and maps the four object pins onto a 3-bit-per-channel RGB
// stream. Everything is registered in the clkvideo domain.
//
// Only csync falling edges at least LINE_MIN cycles after the previous
// accepted edge start an hsync, so equalising and broad-pulse half-line
// edges are dropped and each line gets exactly one HSYNC_W-cycle pulse.
// vsync asserts after VS_THRESH consecutive csync-low cycles and releases
// after VS_END consecutive csync-high cycles.
//
// Optional build macro AY_HSYNC_FLYWHEEL_EN: when defined, a synthetic hsync
// is emitted whenever the line counter reaches LINE_MAX without an accepted
// edge, so downstream stays locked through csync dropouts.
//
// Ports:
//   clkvideo     in   video clock
//   rst_n        in   asynchronous active-low reset
//   csync_n      in   AY composite sync, active-low, asynchronous
//   ball_in      in   ball object, active-high, asynchronous
//   rp_in        in   right-player object
//   lp_in        in   left-player object
//   sf_in        in   score/field object
//   ri, gi, bi   out  3-bit red/green/blue, blanked during sync
//   hsync_ext_n  out  separated horizontal sync, active-low
//   vsync_ext_n  out  separated vertical sync, active-low
module ay_video_frontend
  import ay_video_pkg::*;
#(
  parameter int         CLKVIDEO = 6500,
  parameter logic [8:0] COL_BALL = COL_BALL_DEF,
  parameter logic [8:0] COL_RP   = COL_RP_DEF,
  parameter logic [8:0] COL_LP   = COL_LP_DEF,
  parameter logic [8:0] COL_SF   = COL_SF_DEF
) (
  input  logic       clkvideo,
  input  logic       rst_n,
  input  logic       csync_n,
  input  logic       ball_in,
  input  logic       rp_in,
  input  logic       lp_in,
  input  logic       sf_in,
  output logic [2:0] ri,
  output logic [2:0] gi,
  output logic [2:0] bi,
  output logic       hsync_ext_n,
  output logic       vsync_ext_n
);

  localparam logic [CNT_W-1:0] HSYNC_W   = CNT_W'(hsync_w(CLKVIDEO));
  localparam logic [CNT_W-1:0] LINE_MIN  = CNT_W'(line_min(CLKVIDEO));
  localparam logic [CNT_W-1:0] VS_THRESH = CNT_W'(vs_thresh(CLKVIDEO));
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(vs_end(CLKVIDEO));
`ifdef AY_HSYNC_FLYWHEEL_EN
  localparam logic [CNT_W-1:0] LINE_MAX  = CNT_W'(line_max(CLKVIDEO));
`endif

  // Synchronised inputs; obj_s is {ball, rp, lp, sf}
  logic       csync_s;
  logic [3:0] obj_s;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_csync (
    .clk   (clkvideo),
    .rst_n (rst_n),
    .d     (csync_n),
    .q     (csync_s)
  );

  sync_2ff #(.WIDTH(4), .RST_VAL(4'b0000)) u_sync_obj (
    .clk   (clkvideo),
    .rst_n (rst_n),
    .d     ({ball_in, rp_in, lp_in, sf_in}),
    .q     (obj_s)
  );

  // State
  logic             csync_d;
  logic [CNT_W-1:0] line_cnt, low_cnt, high_cnt, hs_cnt;
  vs_state_t        vs_state;
  logic             hs_n_q;
  rgb_t             rgb_q;

  // Next state
  logic             fall, accept;
  logic [CNT_W-1:0] line_nxt, low_nxt, high_nxt, hs_nxt;
  vs_state_t        vs_nxt;
  rgb_t             rgb_nxt;

  assign fall = csync_d & ~csync_s;

`ifdef AY_HSYNC_FLYWHEEL_EN
  assign accept = (fall && (line_cnt >= LINE_MIN)) || (line_cnt >= LINE_MAX);
`else
  assign accept = fall && (line_cnt >= LINE_MIN);
`endif

  always_comb begin
    line_nxt = sat_inc(line_cnt);
    hs_nxt   = hs_cnt;
    low_nxt  = '0;
    high_nxt = '0;
    vs_nxt   = vs_state;
    rgb_nxt  = '0;

    // LINE_MIN > HSYNC_W, so an accept never lands inside a running pulse
    if (accept) begin
      line_nxt = '0;
      hs_nxt   = HSYNC_W;
    end else if (hs_cnt != '0) begin
      hs_nxt = hs_cnt - 1'b1;
    end

    if (csync_s) high_nxt = sat_inc(high_cnt);
    else         low_nxt  = sat_inc(low_cnt);

    case (vs_state)
      VS_IDLE:   if (low_cnt >= VS_THRESH) vs_nxt = VS_ACTIVE;
      VS_ACTIVE: if (high_cnt >= VS_END)   vs_nxt = VS_IDLE;
      default:   vs_nxt = VS_IDLE;
    endcase

    // Blank on the same edge the syncs assert so colour never leaks into sync
    if (csync_s && (hs_nxt == '0) && (vs_nxt == VS_IDLE)) begin
      if      (obj_s[3]) rgb_nxt = rgb_t'(COL_BALL);
      else if (obj_s[2]) rgb_nxt = rgb_t'(COL_RP);
      else if (obj_s[1]) rgb_nxt = rgb_t'(COL_LP);
      else if (obj_s[0]) rgb_nxt = rgb_t'(COL_SF);
    end
  end

  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      csync_d  <= 1'b1;
      line_cnt <= LINE_MIN;  // first edge after reset is accepted at once
      low_cnt  <= '0;
      high_cnt <= '0;
      hs_cnt   <= '0;
      vs_state <= VS_IDLE;
      hs_n_q   <= 1'b1;
      rgb_q    <= '0;
    end else begin
      csync_d  <= csync_s;
      line_cnt <= line_nxt;
      low_cnt  <= low_nxt;
      high_cnt <= high_nxt;
      hs_cnt   <= hs_nxt;
      vs_state <= vs_nxt;
      hs_n_q   <= (hs_nxt == '0);
      rgb_q    <= rgb_nxt;
    end
  end

  assign hsync_ext_n = hs_n_q;
  assign vsync_ext_n = (vs_state == VS_IDLE);
  assign ri          = rgb_q.r;
  assign gi          = rgb_q.g;
  assign bi          = rgb_q.b;

endmodule

// File: tb/tb_ay_video_frontend.sv
// Directed bench for ay_video_frontend at CLKVIDEO = 6500 kHz.
// Honours AY_HSYNC_FLYWHEEL_EN when the same macro is defined for the build.
module tb_ay_video_frontend;

  localparam int HSYNC_W   = 30;
  localparam int LINE_MIN  = 312;
  localparam int LINE_PER  = 443;  // flywheel period: LINE_MAX + 1
  localparam int VS_ASSERT = 81;   // 78 + 3 from csync pin fall
  localparam int VS_DEASS  = 133;  // 130 + 3 from csync pin rise
  localparam int LAT       = 3;

  // Clock / reset
  logic clkvideo = 1'b0;
  always #5 clkvideo = ~clkvideo;

  logic       rst_n, csync_n, ball_in, rp_in, lp_in, sf_in;
  logic [2:0] ri, gi, bi;
  logic       hsync_ext_n, vsync_ext_n;

  ay_video_frontend dut (
    .clkvideo    (clkvideo),
    .rst_n       (rst_n),
    .csync_n     (csync_n),
    .ball_in     (ball_in),
    .rp_in       (rp_in),
    .lp_in       (lp_in),
    .sf_in       (sf_in),
    .ri          (ri),
    .gi          (gi),
    .bi          (bi),
    .hsync_ext_n (hsync_ext_n),
    .vsync_ext_n (vsync_ext_n)
  );

  int cyc = 0;
  always @(posedge clkvideo) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Scoreboard: expected hsync fall cycles, plus observed edges from the monitor
  logic [31:0] exp_q[$];
  int hs_falls[$], hs_widths[$], vs_falls[$], vs_rises[$];
  logic hs_prev = 1'b1;
  logic vs_prev = 1'b1;
  int   hs_run  = 0;

  always @(negedge clkvideo) begin
    hs_prev <= hsync_ext_n;
    vs_prev <= vsync_ext_n;
    if (hs_prev && !hsync_ext_n) hs_falls.push_back(cyc);
    if (!hsync_ext_n) hs_run <= hs_run + 1;
    else begin
      if (!hs_prev) hs_widths.push_back(hs_run);
      hs_run <= 0;
    end
    if (vs_prev && !vsync_ext_n) vs_falls.push_back(cyc);
    if (!vs_prev && vsync_ext_n) vs_rises.push_back(cyc);
  end

  // Line-timing model: edge accepted when >= LINE_MIN+1 pin cycles after the last one
  int last_acc = 0;
  bit have_acc = 0;

  // Driver tasks
  task automatic tick();
    @(posedge clkvideo);
    #1;
  endtask

  task automatic model_fall();
    if (!have_acc || (cyc - last_acc) >= LINE_MIN + 1) begin
      exp_q.push_back(32'(cyc + LAT));
      last_acc = cyc;
      have_acc = 1;
    end
  endtask

  task automatic pulse(input int lo, input int hi);
    csync_n = 1'b0;
    model_fall();
    repeat (lo) tick();
    csync_n = 1'b1;
    repeat (hi) tick();
  endtask

  task automatic clear_obs();
    exp_q.delete();
    hs_falls.delete();
    hs_widths.delete();
    vs_falls.delete();
    vs_rises.delete();
  endtask

  task automatic set_obj(input logic [3:0] o);
    {ball_in, rp_in, lp_in, sf_in} = o;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    csync_n = 1'b1;
    set_obj(4'b0000);
    repeat (3) tick();
    chk_cnt++;
    if (hsync_ext_n !== 1'b1) $display("FAIL reset_hsync: got %b want 1", hsync_ext_n);
    else pass_cnt++;
    chk_cnt++;
    if (vsync_ext_n !== 1'b1) $display("FAIL reset_vsync: got %b want 1", vsync_ext_n);
    else pass_cnt++;
    chk_cnt++;
    if ({ri, gi, bi} !== 9'o000) $display("FAIL reset_rgb: got %o want 000", {ri, gi, bi});
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) tick();
    chk_cnt++;
    if ({hsync_ext_n, vsync_ext_n, ri, gi, bi} !== 11'b11_000000000)
      $display("FAIL post_reset_idle: got %b want 11000000000", {hsync_ext_n, vsync_ext_n, ri, gi, bi});
    else pass_cnt++;
    clear_obs();
    have_acc = 0;
  endtask

  task automatic test_hsync_lines();
    clear_obs();
    set_obj(4'b1000);
    for (int l = 0; l < 4; l++) begin
      csync_n = 1'b0;
      model_fall();
      repeat (10) tick();
      chk_cnt++;
      if ({ri, gi, bi} !== 9'o000) $display("FAIL line%0d_rgb_in_sync: got %o want 000", l, {ri, gi, bi});
      else pass_cnt++;
      repeat (20) tick();
      csync_n = 1'b1;
      repeat (100) tick();
      chk_cnt++;
      if ({ri, gi, bi} !== 9'o777) $display("FAIL line%0d_rgb_active: got %o want 777", l, {ri, gi, bi});
      else pass_cnt++;
      repeat (286) tick();
    end
    chk_cnt++;
    if (hs_falls.size() != exp_q.size() || hs_widths.size() != exp_q.size())
      $display("FAIL hs_line_count: got %0d falls %0d widths want %0d", hs_falls.size(), hs_widths.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < hs_falls.size() && i < hs_widths.size(); i++) begin
      chk_cnt++;
      if (hs_falls[i] !== int'(exp_q[i])) $display("FAIL hs_line_fall[%0d]: got %0d want %0d", i, hs_falls[i], exp_q[i]);
      else pass_cnt++;
      chk_cnt++;
      if (hs_widths[i] !== HSYNC_W) $display("FAIL hs_line_width[%0d]: got %0d want %0d", i, hs_widths[i], HSYNC_W);
      else pass_cnt++;
    end
    chk_cnt++;
    if (vs_falls.size() != 0) $display("FAIL hs_line_no_vsync: got %0d vsync falls want 0", vs_falls.size());
    else pass_cnt++;
  endtask

  task automatic test_vsync();
    int lo, hi, c_b, c_r;
    clear_obs();
    set_obj(4'b1000);
    c_b = 0;
    c_r = 0;
    for (int i = 0; i < 15; i++) begin
      lo = (i >= 5 && i < 10) ? 178 : 15;
      hi = 208 - lo;
      if (i == 5) c_b = cyc;
      csync_n = 1'b0;
      model_fall();
      repeat (lo) tick();
      csync_n = 1'b1;
      if (i == 10) c_r = cyc;
      if (i == 7) begin
        repeat (10) tick();
        chk_cnt++;
        if ({vsync_ext_n, ri, gi, bi} !== 10'b0_000000000)
          $display("FAIL vs_gap_blank: got vs=%b rgb=%o want vs=0 rgb=000", vsync_ext_n, {ri, gi, bi});
        else pass_cnt++;
        repeat (hi - 10) tick();
      end else begin
        repeat (hi) tick();
      end
    end
    pulse(30, 386);
    pulse(30, 386);
    chk_cnt++;
    if (vs_falls.size() != 1 || vs_rises.size() != 1)
      $display("FAIL vs_count: got %0d falls %0d rises want 1 1", vs_falls.size(), vs_rises.size());
    else pass_cnt++;
    if (vs_falls.size() > 0) begin
      chk_cnt++;
      if (vs_falls[0] !== c_b + VS_ASSERT) $display("FAIL vs_fall: got %0d want %0d", vs_falls[0], c_b + VS_ASSERT);
      else pass_cnt++;
    end
    if (vs_rises.size() > 0) begin
      chk_cnt++;
      if (vs_rises[0] !== c_r + VS_DEASS) $display("FAIL vs_rise: got %0d want %0d", vs_rises[0], c_r + VS_DEASS);
      else pass_cnt++;
    end
    chk_cnt++;
    if (hs_falls.size() != exp_q.size())
      $display("FAIL vs_hs_count: got %0d want %0d", hs_falls.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < hs_falls.size(); i++) begin
      chk_cnt++;
      if (hs_falls[i] !== int'(exp_q[i])) $display("FAIL vs_hs_fall[%0d]: got %0d want %0d", i, hs_falls[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_colours();
    logic [3:0] obj_v[8];
    logic [8:0] rgb_v[8];
    obj_v = '{4'b1111, 4'b0110, 4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b0000, 4'b1000};
    rgb_v = '{9'o777,  9'o070,  9'o777,  9'o700,  9'o070,  9'o700,  9'o000,  9'o777};
    clear_obs();
    pulse(30, 10);
    for (int i = 0; i < 8; i++) begin
      set_obj(obj_v[i]);
      repeat (3) tick();
      chk_cnt++;
      if ({ri, gi, bi} !== rgb_v[i]) $display("FAIL colour[%0d] obj=%b: got %o want %o", i, obj_v[i], {ri, gi, bi}, rgb_v[i]);
      else pass_cnt++;
    end
    set_obj(4'b1111);
    repeat (376 - 24) tick();
    // Blanking follows the csync fall with the same three-edge latency
    csync_n = 1'b0;
    model_fall();
    repeat (2) tick();
    chk_cnt++;
    if ({ri, gi, bi} !== 9'o777) $display("FAIL colour_blank_early: got %o want 777", {ri, gi, bi});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({ri, gi, bi} !== 9'o000) $display("FAIL colour_blank: got %o want 000", {ri, gi, bi});
    else pass_cnt++;
    repeat (27) tick();
    csync_n = 1'b1;
    repeat (386) tick();
  endtask

  task automatic test_glitch();
    clear_obs();
    set_obj(4'b1000);
    pulse(30, 171);
    csync_n = 1'b0;
    model_fall();
    repeat (3) tick();
    chk_cnt++;
    if ({hsync_ext_n, vsync_ext_n, ri, gi, bi} !== 11'b11_000000000)
      $display("FAIL glitch_blank: got hs=%b vs=%b rgb=%o want hs=1 vs=1 rgb=000", hsync_ext_n, vsync_ext_n, {ri, gi, bi});
    else pass_cnt++;
    repeat (7) tick();
    csync_n = 1'b1;
    repeat (205) tick();
    pulse(30, 386);
    chk_cnt++;
    if (hs_falls.size() != 2 || exp_q.size() != 2)
      $display("FAIL glitch_hs_count: got %0d want 2 (model %0d)", hs_falls.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < hs_falls.size(); i++) begin
      chk_cnt++;
      if (hs_falls[i] !== int'(exp_q[i])) $display("FAIL glitch_hs_fall[%0d]: got %0d want %0d", i, hs_falls[i], exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (vs_falls.size() != 0) $display("FAIL glitch_no_vsync: got %0d falls want 0", vs_falls.size());
    else pass_cnt++;
  endtask

  task automatic test_dropout();
    int c0;
    clear_obs();
    c0 = cyc;
    pulse(30, 386);
    repeat (1000) tick();
`ifdef AY_HSYNC_FLYWHEEL_EN
    exp_q.push_back(32'(c0 + LAT + LINE_PER));
    exp_q.push_back(32'(c0 + LAT + 2 * LINE_PER));
`endif
    chk_cnt++;
    if (hs_falls.size() != exp_q.size())
      $display("FAIL dropout_hs_count: got %0d want %0d", hs_falls.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < hs_falls.size(); i++) begin
      chk_cnt++;
      if (hs_falls[i] !== int'(exp_q[i])) $display("FAIL dropout_hs_fall[%0d]: got %0d want %0d", i, hs_falls[i], exp_q[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < hs_widths.size(); i++) begin
      chk_cnt++;
      if (hs_widths[i] !== HSYNC_W) $display("FAIL dropout_hs_width[%0d]: got %0d want %0d", i, hs_widths[i], HSYNC_W);
      else pass_cnt++;
    end
    chk_cnt++;
    if (hsync_ext_n !== 1'b1) $display("FAIL dropout_hs_idle: got %b want 1", hsync_ext_n);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_hsync();
    clear_obs();
    set_obj(4'b1000);
    csync_n = 1'b0;
    model_fall();
    repeat (21) tick();  // hs_cnt now 12
    chk_cnt++;
    if (hsync_ext_n !== 1'b0) $display("FAIL mid_hsync_active: got %b want 0", hsync_ext_n);
    else pass_cnt++;
    rst_n = 1'b0;
    csync_n = 1'b1;
    #1;
    chk_cnt++;
    if ({hsync_ext_n, vsync_ext_n, ri, gi, bi} !== 11'b11_000000000)
      $display("FAIL async_reset: got hs=%b vs=%b rgb=%o want 1 1 000", hsync_ext_n, vsync_ext_n, {ri, gi, bi});
    else pass_cnt++;
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    clear_obs();
    have_acc = 0;
    pulse(30, 386);
    pulse(30, 386);
    chk_cnt++;
    if (hs_falls.size() != 2 || hs_widths.size() != 2)
      $display("FAIL post_reset_hs_count: got %0d falls %0d widths want 2 2", hs_falls.size(), hs_widths.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < hs_falls.size() && i < hs_widths.size(); i++) begin
      chk_cnt++;
      if (hs_falls[i] !== int'(exp_q[i])) $display("FAIL post_reset_fall[%0d]: got %0d want %0d", i, hs_falls[i], exp_q[i]);
      else pass_cnt++;
      chk_cnt++;
      if (hs_widths[i] !== HSYNC_W) $display("FAIL post_reset_width[%0d]: got %0d want %0d", i, hs_widths[i], HSYNC_W);
      else pass_cnt++;
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_hsync_lines();
    test_vsync();
    test_colours();
    test_glitch();
    test_dropout();
    test_reset_mid_hsync();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
